// File: rtl/plot_arbiter_pkg.sv
// Shared constants, state encoding and packed-bus helper for the VGA plot arbiter.
package plot_arbiter_pkg;

    localparam int unsigned SCR_W = 160;
    localparam int unsigned SCR_H = 120;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 3;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_FW  = 16;
    localparam int unsigned BUS_W   = MAX_REQ * MAX_FW;

    localparam logic [0:0] ST_SERVE = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Extract field idx of width w from a zero-extended packed requester bus.
    function automatic logic [MAX_FW-1:0] bus_slice(input logic [BUS_W-1:0] bus,
                                                    input int unsigned      idx,
                                                    input int unsigned      w);
        logic [BUS_W-1:0] sh;
        sh = bus >> (idx * w);
        return MAX_FW'(sh) & MAX_FW'((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/plot_arbiter_rr.sv
// Round-robin one-hot grant generator; pointer moves past the winner when advance is high.
module plot_arbiter_rr #(
    parameter int unsigned N_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic                       advance,
    output logic [N_REQ-1:0]           grant_c,
    output logic [$clog2(N_REQ)-1:0]   grant_idx_c,
    output logic                       grant_vld_c
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;
    logic             found_c;
    logic [PTR_W-1:0] idx_c;

    // First requester at or after the pointer, wrapping at N_REQ-1.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found_c && req[cand[PTR_W-1:0]]) begin
                found_c = 1'b1;
                idx_c   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant_c     = '0;
        grant_idx_c = idx_c;
        grant_vld_c = advance && found_c;
        rr_ptr_d    = rr_ptr_q;
        if (grant_vld_c) begin
            grant_c[idx_c] = 1'b1;
            rr_ptr_d       = (idx_c == PTR_W'(N_REQ - 1)) ? '0 : idx_c + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the VGA adapter pixel port between drawing requesters, with a
// top-priority full-screen clear engine.
module plot_arbiter
    import plot_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*X_W-1:0]  req_x,
    input  logic [N_REQ*Y_W-1:0]  req_y,
    input  logic [N_REQ*C_W-1:0]  req_color,
    output logic [N_REQ-1:0]      grant,
    input  logic                  clear_start,
    input  logic [C_W-1:0]        clear_color,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [X_W-1:0]        x_out,
    output logic [Y_W-1:0]        y_out,
    output logic [C_W-1:0]        color_out,
    output logic                  writeEn
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic [0:0]     state_q, state_d;
    logic [C_W-1:0] clear_color_q, clear_color_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [C_W-1:0] color_q, color_d;
    logic           we_q, we_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic             arb_en_c;
    logic [PTR_W-1:0] gidx_c;
    logic             gvld_c;
    logic [X_W-1:0]   sel_x_c;
    logic [Y_W-1:0]   sel_y_c;
    logic [C_W-1:0]   sel_c_c;
    logic             in_range_c;

    // A clear request pre-empts arbitration in the cycle it arrives.
    assign arb_en_c = (state_q == ST_SERVE) && !clear_start;

    plot_arbiter_rr #(
        .N_REQ (N_REQ)
    ) u_rr (
        .clk         (clk),
        .rst_n       (resetn),
        .req         (req),
        .advance     (arb_en_c),
        .grant_c     (grant),
        .grant_idx_c (gidx_c),
        .grant_vld_c (gvld_c)
    );

    assign sel_x_c    = X_W'(bus_slice(BUS_W'(req_x), 32'(gidx_c), X_W));
    assign sel_y_c    = Y_W'(bus_slice(BUS_W'(req_y), 32'(gidx_c), Y_W));
    assign sel_c_c    = C_W'(bus_slice(BUS_W'(req_color), 32'(gidx_c), C_W));
    assign in_range_c = (sel_x_c < X_W'(SCR_W)) && (sel_y_c < Y_W'(SCR_H));

    always_comb begin
        state_d       = state_q;
        clear_color_d = clear_color_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        x_d           = x_q;
        y_d           = y_q;
        color_d       = color_q;
        we_d          = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;

        if (state_q == ST_SERVE) begin
            if (clear_start) begin
                clear_color_d = clear_color;
                state_d       = ST_CLEAR;
                busy_d        = 1'b1;
                cx_d          = '0;
                cy_d          = '0;
            end else if (gvld_c) begin
                x_d     = sel_x_c;
                y_d     = sel_y_c;
                color_d = sel_c_c;
                we_d    = in_range_c;
            end
        end else begin
            // The cycle showing the final pixel is still CLEAR; leave afterwards.
            if (done_q) begin
                state_d = ST_SERVE;
                busy_d  = 1'b0;
            end else begin
                x_d     = cx_q;
                y_d     = cy_q;
                color_d = clear_color_q;
                we_d    = 1'b1;
                if (cx_q == X_W'(SCR_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == Y_W'(SCR_H - 1)) begin
                        cy_d   = '0;
                        done_d = 1'b1;
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_SERVE;
            clear_color_q <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            color_q       <= '0;
            we_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            clear_color_q <= clear_color_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            x_q           <= x_d;
            y_q           <= y_d;
            color_q       <= color_d;
            we_q          <= we_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign color_out  = color_q;
    assign writeEn    = we_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) between several drawing requesters, e.g. player, enemy and HUD drawers inside the processor.
- Includes a built-in frame-clear engine that sweeps the full 160x120 screen with a background colour at top priority.
- Sits between the drawing units and vga_adapter; its registered outputs drive the adapter's x/y/colour/plot inputs directly.

Parameters:
N_REQ, 3, number of requesters (2..8)
SCR_W, 160, screen width in pixels
SCR_H, 120, screen height in pixels
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
C_W, 3, colour width

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester pixel write request, held until granted
req_x  in  N_REQ*X_W  packed x; requester i occupies bits [i*X_W +: X_W]
req_y  in  N_REQ*Y_W  packed y, same packing
req_color  in  N_REQ*C_W  packed colour, same packing
grant  out  N_REQ  one-hot, one-cycle pulse: requester's pixel sampled this cycle
clear_start  in  1  pulse: begin full-screen clear
clear_color  in  C_W  background colour, sampled on accepted clear_start
clear_busy  out  1  high while the clear sweep runs
clear_done  out  1  one-cycle pulse on the final clear pixel
x_out  out  X_W  registered pixel x to the adapter
y_out  out  Y_W  registered pixel y to the adapter
color_out  out  C_W  registered pixel colour to the adapter
writeEn  out  1  registered plot strobe to the adapter

Behaviour:
- Reset (async, resetn=0): state=SERVE, rr_ptr=0, grant=0, writeEn=0, x_out=0, y_out=0, color_out=0, clear_busy=0, clear_done=0, clear counters 0.
- States: SERVE, CLEAR.
- SERVE:
  - Each cycle, grant at most one requester with req=1. Search is round-robin starting at rr_ptr, wrapping at N_REQ-1 to 0.
  - Grant to i at cycle T: req_*[i] sampled at T, x_out/y_out/color_out/writeEn updated at T+1. Latency is 1 cycle.
  - rr_ptr becomes (i+1) mod N_REQ.
  - No req: writeEn=0 next cycle, rr_ptr unchanged.
  - A requester keeps req high and its data stable until it sees grant. It may drop req after grant, or hold it for back-to-back pixels.
- Out-of-range pixel (x>=SCR_W or y>=SCR_H): still granted, but writeEn stays 0 for it; rr_ptr still advances.
- clear_start in SERVE at cycle T:
  - No grant is issued at T; clear_color is latched.
  - At T+1: state=CLEAR, clear_busy=1.
  - If clear_start coincides with requests, the requests wait.
- CLEAR:
  - Emit one pixel per cycle in raster order, x fastest: (0,0),(1,0)..(159,0),(0,1)..(159,119). Exactly SCR_W*SCR_H = 19200 writeEn pulses.
  - First writeEn appears at T+2. grant is held at 0 throughout.
  - clear_done=1 in the same cycle as writeEn for (159,119).
  - Next cycle: clear_busy=0, state=SERVE, arbitration resumes from the unchanged rr_ptr.
- clear_start while in CLEAR is ignored and does not restart the sweep.
- Counter widths are X_W/Y_W. Wrap x at SCR_W-1, not at 2^X_W.
- Reset mid-clear aborts the sweep immediately (async). The first cycle after release is SERVE with no writes.
- grant is combinationally derived from registered state and req. It has no combinational path to writeEn.

Decomposition:
- Shared package holds SCR_W/SCR_H, coordinate and colour widths, the state encoding (SERVE, CLEAR), and the packed-bus slice helper.
- Natural sub-module: rr_arbiter, an N_REQ round-robin one-hot grant generator with a pointer-advance input. The clear counter and output register stay in plot_arbiter.

Test Plan:
- Reset release, req=3'b001, x=10, y=20, colour=5 -> grant=001 at T; at T+1 writeEn=1, x_out=10, y_out=20, color_out=5.
- req=3'b111 held for 6 cycles with rr_ptr=0 -> grant sequence 001,010,100,001,010,100; 6 consecutive writeEn pulses carrying each requester's data.
- req=3'b101 held -> grants alternate 001,100,001,100; requester 1 never granted.
- clear_start with clear_color=3'b010 while req=3'b010 pending:
  - exactly 19200 writeEn pulses, first (0,0), last (159,119), all colour 2;
  - clear_done aligned with the last pulse; grant=0 throughout;
  - grant=010 on the first cycle after clear_busy falls.
- req0 with x=160, y=5 -> grant=001, no writeEn; the next req0 at (159,119) is written.
- Clear started, resetn pulsed low after 500 pixels -> all outputs 0 immediately; after release, no further clear writes, and a second clear_start runs a full 19200-pixel sweep.
